mips_mc_control: RTL
====================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have parameter OPW, default 6, giving the opcode field width.
REQ-002 SHALL have parameter STW, default 4, giving the state encoding width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 opcode  input  OPW  instr[31:26], taken from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory handshake; access completes in a cycle with mem_ready=1.
REQ-008 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  classic multicycle datapath enables/selects.
REQ-009 alu_src_b, alu_op, pc_source  output  2 each  datapath selects.
REQ-010 ext_op  output  1  immediate extender mode: 1=sign extend, 0=zero extend.
REQ-011 instr_done  output  1  high in the final cycle of each instruction.
REQ-012 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-013 state  output  STW  current state, for debug.

Function
REQ-014 States SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11.
REQ-015 Outputs SHALL decode from state; the only Mealy terms are ir_write, pc_write and instr_done gated by mem_ready, and illegal_op decoded from opcode.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_b=01, ir_write=pc_write=mem_ready; hold FETCH while mem_ready=0, else go to DECODE.
REQ-017 DECODE: alu_src_b=11, ext_op=1.
  - Next state by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP.
  - Any other opcode -> FETCH, with illegal_op=1 for that cycle.
REQ-018 MEMADR: alu_src_a=1, alu_src_b=10, ext_op=1; next MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: mem_read=1, iord=1; hold until mem_ready, then go to MEMWB.
REQ-020 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; instr_done=1; next FETCH.
REQ-021 MEMWR: mem_write=1, iord=1; hold until mem_ready; instr_done=mem_ready; then go to FETCH.
REQ-022 EXEC: alu_src_a=1, alu_op=10; next ALUWB.
REQ-023 ALUWB: reg_write=1, reg_dst=1; instr_done=1; next FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01; instr_done=1; next FETCH.
REQ-025 JUMP: pc_write=1, pc_source=10; instr_done=1; next FETCH.
REQ-026 Zero-wait latency SHALL be: R-type 4, lw 5, sw 4, beq 3, j 3 cycles; each mem_ready=0 cycle adds exactly one cycle.
REQ-027 Every output not listed for a state SHALL be 0; mem_read and mem_write SHALL never both be 1.
REQ-028 Unused state encodings SHALL go to FETCH on the next edge with all enables 0.

Reset
REQ-029 While reset=1: state=FETCH, and all outputs are 0, including the gated mem_read.
REQ-030 Reset asserted mid-instruction SHALL abort it; no reg_write, mem_write or pc_write follows deassertion until a new FETCH completes.

Configuration
REQ-031 With MIPS_MC_IMM_ALU_EN defined, DECODE SHALL route 001000/001010 (addi/slti, ext_op=1) and 001100/001101 (andi/ori, ext_op=0) to IMMEX.
  - IMMEX: alu_src_a=1, alu_src_b=10, alu_op=11.
  - IMMWB: reg_write=1, reg_dst=0, instr_done=1; next FETCH.
  - ext_op SHALL hold its DECODE value through IMMEX.
REQ-032 Without MIPS_MC_IMM_ALU_EN, those opcodes SHALL be illegal (REQ-017), and IMMEX/IMMWB SHALL be unreachable (REQ-028).

Structure
REQ-033 Shared package mips_pkg SHALL hold the opcode constants, state encodings and ALUOp/PCSource/ALUSrcB codes.
REQ-034 Single module; no sub-modules.

Verification
REQ-035 Reset mid-MEMRD, then release with mem_ready=1 -> state=0, all enables 0 during reset; next instruction fetched normally.
REQ-036 lw (100011), mem_ready=1 constantly -> states 0,1,2,3,4; reg_write=1 in cycle 5 only; instr_done once.
REQ-037 sw with mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles; instr_done only on the ready cycle.
REQ-038 beq with zero=1 -> pc_write_cond=1, pc_source=01 in the BRANCH cycle; 3 cycles total.
REQ-039 opcode 111111 in DECODE -> illegal_op=1 for exactly one cycle; next state FETCH; no write enables asserted.
REQ-040 andi (001100) with MIPS_MC_IMM_ALU_EN -> ext_op=0, states 0,1,10,11; without the macro -> illegal_op pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states, and datapath select codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

endpackage

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM; outputs decode from state, gated by mem_ready where a memory access completes.
// Optional immediate ALU ops (addi/slti/andi/ori) are enabled with `define MIPS_MC_IMM_ALU_EN.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           ext_op,
  output logic           instr_done,
  output logic           illegal_op,
  output logic [STW-1:0] state
);

  state_t cur;

  // The zero flag is consumed by the datapath through pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  logic is_r, is_lw, is_sw, is_beq, is_j, is_imm_s, is_imm_z, is_imm;
  assign is_r   = (opcode == OPW'(OP_RTYPE));
  assign is_lw  = (opcode == OPW'(OP_LW));
  assign is_sw  = (opcode == OPW'(OP_SW));
  assign is_beq = (opcode == OPW'(OP_BEQ));
  assign is_j   = (opcode == OPW'(OP_J));
`ifdef MIPS_MC_IMM_ALU_EN
  assign is_imm_s = (opcode == OPW'(OP_ADDI)) || (opcode == OPW'(OP_SLTI));
  assign is_imm_z = (opcode == OPW'(OP_ANDI)) || (opcode == OPW'(OP_ORI));
`else
  assign is_imm_s = 1'b0;
  assign is_imm_z = 1'b0;
`endif
  assign is_imm = is_imm_s || is_imm_z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:  if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          if (is_r)                cur <= S_EXEC;
          else if (is_lw || is_sw) cur <= S_MEMADR;
          else if (is_beq)         cur <= S_BRANCH;
          else if (is_j)           cur <= S_JUMP;
          else if (is_imm)         cur <= S_IMMEX;
          else                     cur <= S_FETCH;
        end
        S_MEMADR: cur <= is_sw ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWR:  if (mem_ready) cur <= S_FETCH;
        S_EXEC:   cur <= S_ALUWB;
        S_IMMEX:  cur <= S_IMMWB;
        default:  cur <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    ext_op        = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    // Everything is forced low while reset is held, including the fetch read.
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM2;
          ext_op     = !is_imm_z;
          illegal_op = !(is_r || is_lw || is_sw || is_beq || is_j || is_imm);
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          ext_op    = 1'b1;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        S_IMMEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_IMM;
          ext_op    = is_imm_s;
        end
        S_IMMWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = STW'(cur);

endmodule
